// File: rtl/dut_top.sv
// Looped-back serial framer: preamble + (optionally scrambled) payload + parity, with correlator RX and serial replay.
// Optional feature macro: DUT_TOP_SCRAMBLER_EN enables the 7-bit TX scrambler / RX descrambler.
module dut_top #(
    parameter int                 PRE_LEN     = 16,
    parameter logic [PRE_LEN-1:0] PRE_PATTERN = 16'hF0A5,
    parameter int                 DATA_BITS   = 4,
    parameter logic [6:0]         SCR_SEED    = 7'b1011101
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Start,
    input  logic Input,
    output logic Antenna,
    output logic Output,
    output logic Error
);

    localparam int MAXC = (PRE_LEN > DATA_BITS) ? PRE_LEN : DATA_BITS;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {TX_IDLE, TX_PRE, TX_DATA, TX_PAR} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_CAP, RX_CHK, RX_PLAY} rx_state_t;

    tx_state_t          tx_st_q;
    logic [CW-1:0]      tx_cnt_q;
    logic [PRE_LEN-1:0] pre_q;
    logic               tx_par_q;
    logic               ant_q;
    logic               tx_bit;

    rx_state_t            rx_st_q;
    logic [CW-1:0]        rx_cnt_q;
    logic [PRE_LEN-1:0]   corr_q;
    logic [PRE_LEN-1:0]   corr_d;
    logic [DATA_BITS-1:0] rx_buf_q;
    logic                 rx_par_q;
    logic                 rx_bit;
    logic                 out_q;
    logic                 err_q;

    logic accept;
    logic collide;
    logic perr;

`ifdef DUT_TOP_SCRAMBLER_EN
    logic [6:0] tx_lfsr_q;
    logic [6:0] rx_lfsr_q;
    logic       tx_scr;
    logic       rx_scr;

    assign tx_scr = tx_lfsr_q[6] ^ tx_lfsr_q[3];
    assign rx_scr = rx_lfsr_q[6] ^ rx_lfsr_q[3];
    assign tx_bit = Input ^ tx_scr;
    assign rx_bit = ant_q ^ rx_scr;
`else
    assign tx_bit = Input;
    assign rx_bit = ant_q;
`endif

    assign accept  = Start && (tx_st_q == TX_IDLE);
    assign collide = Start && (tx_st_q != TX_IDLE);
    assign perr    = (rx_st_q == RX_CHK) && (rx_par_q ^ ant_q);
    assign corr_d  = {corr_q[PRE_LEN-2:0], ant_q};

    assign Antenna = ant_q;
    assign Output  = out_q;
    assign Error   = err_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            tx_st_q  <= TX_IDLE;
            tx_cnt_q <= '0;
            pre_q    <= '0;
            tx_par_q <= 1'b0;
            ant_q    <= 1'b0;
`ifdef DUT_TOP_SCRAMBLER_EN
            tx_lfsr_q <= SCR_SEED;
`endif
        end else begin
            unique case (tx_st_q)
                TX_IDLE: begin
                    ant_q    <= 1'b0;
                    tx_cnt_q <= '0;
                    tx_par_q <= 1'b0;
                    if (Start) begin
                        tx_st_q <= TX_PRE;
                        pre_q   <= PRE_PATTERN;
`ifdef DUT_TOP_SCRAMBLER_EN
                        tx_lfsr_q <= SCR_SEED;
`endif
                    end
                end
                TX_PRE: begin
                    ant_q <= pre_q[PRE_LEN-1];
                    pre_q <= pre_q << 1;
                    if (tx_cnt_q == CW'(PRE_LEN - 1)) begin
                        tx_cnt_q <= '0;
                        tx_st_q  <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TX_DATA: begin
                    ant_q    <= tx_bit;
                    tx_par_q <= tx_par_q ^ tx_bit;
`ifdef DUT_TOP_SCRAMBLER_EN
                    tx_lfsr_q <= {tx_lfsr_q[5:0], tx_scr};
`endif
                    if (tx_cnt_q == CW'(DATA_BITS - 1)) begin
                        tx_cnt_q <= '0;
                        tx_st_q  <= TX_PAR;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TX_PAR: begin
                    // first edge sends parity, second edge drops the line and goes idle
                    if (tx_cnt_q == '0) begin
                        ant_q    <= tx_par_q;
                        tx_cnt_q <= CW'(1);
                    end else begin
                        ant_q   <= 1'b0;
                        tx_st_q <= TX_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rx_st_q  <= RX_IDLE;
            rx_cnt_q <= '0;
            corr_q   <= '0;
            rx_buf_q <= '0;
            rx_par_q <= 1'b0;
            out_q    <= 1'b0;
`ifdef DUT_TOP_SCRAMBLER_EN
            rx_lfsr_q <= SCR_SEED;
`endif
        end else begin
            corr_q <= corr_d;
            unique case (rx_st_q)
                RX_IDLE: begin
                    out_q <= 1'b0;
                    if (corr_d == PRE_PATTERN) begin
                        rx_st_q  <= RX_CAP;
                        rx_cnt_q <= '0;
                        rx_par_q <= 1'b0;
`ifdef DUT_TOP_SCRAMBLER_EN
                        rx_lfsr_q <= SCR_SEED;
`endif
                    end
                end
                RX_CAP: begin
                    rx_buf_q <= DATA_BITS'({rx_bit, rx_buf_q} >> 1);
                    rx_par_q <= rx_par_q ^ ant_q;
`ifdef DUT_TOP_SCRAMBLER_EN
                    rx_lfsr_q <= {rx_lfsr_q[5:0], rx_scr};
`endif
                    if (rx_cnt_q == CW'(DATA_BITS - 1)) begin
                        rx_cnt_q <= '0;
                        rx_st_q  <= RX_CHK;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_CHK: begin
                    rx_st_q  <= RX_PLAY;
                    rx_cnt_q <= '0;
                end
                RX_PLAY: begin
                    out_q    <= rx_buf_q[0];
                    rx_buf_q <= rx_buf_q >> 1;
                    if (rx_cnt_q == CW'(DATA_BITS - 1)) begin
                        rx_cnt_q <= '0;
                        rx_st_q  <= RX_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (err_q & ~accept) | collide | perr;
        end
    end

endmodule

// File: tb/tb_dut_top.sv
// Randomized frame-level bench for dut_top against a per-edge reference of Antenna/Output/Error.
// Follows DUT_TOP_SCRAMBLER_EN in the same way as the design.
module tb_dut_top;

    localparam int          PL   = 16;
    localparam logic [15:0] PP   = 16'hF0A5;
    localparam int          DB   = 4;
    localparam logic [6:0]  SEED = 7'b1011101;
    localparam int          NK   = 30;

    logic Clock = 1'b0;
    logic Reset;
    logic Start;
    logic Input;
    logic Antenna;
    logic Output;
    logic Error;

    int checks = 0;
    int errors = 0;

    logic exp_ant [0:NK];
    logic exp_out [0:NK];

    dut_top #(
        .PRE_LEN    (PL),
        .PRE_PATTERN(PP),
        .DATA_BITS  (DB),
        .SCR_SEED   (SEED)
    ) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Start  (Start),
        .Input  (Input),
        .Antenna(Antenna),
        .Output (Output),
        .Error  (Error)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    // Expected line and replay values after each edge k of a frame.
    task automatic build_model(input logic [DB-1:0] pay);
        logic [6:0] s;
        logic       ks;
        logic       b;
        logic       par;
        for (int k = 0; k <= NK; k++) begin
            exp_ant[k] = 1'b0;
            exp_out[k] = 1'b0;
        end
        for (int k = 1; k <= PL; k++) exp_ant[k] = PP[PL-k];
        s   = SEED;
        par = 1'b0;
        for (int i = 0; i < DB; i++) begin
`ifdef DUT_TOP_SCRAMBLER_EN
            ks = s[6] ^ s[3];
            s  = {s[5:0], ks};
`else
            ks = 1'b0;
`endif
            b = pay[i] ^ ks;
            exp_ant[PL+1+i] = b;
            par = par ^ b;
            exp_out[PL+DB+3+i] = pay[i];
        end
        exp_ant[PL+DB+1] = par;
    endtask

    task automatic run_frame(input logic [DB-1:0] pay, input bit collide, input int abort_at);
        logic exp_err;
        build_model(pay);
        Input = 1'b0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("ant k0", Antenna, 1'b0);
        check("err k0", Error, 1'b0);
        for (int k = 1; k <= NK; k++) begin
            Start = collide && (k == 10);
            if (k >= PL + 1 && k <= PL + DB) Input = pay[k-PL-1];
            else Input = 1'($urandom_range(0, 1));
            tick();
            Start = 1'b0;
            if (k == abort_at) begin
                #1;
                Reset = 1'b0;
                #1;
                check("ant rst", Antenna, 1'b0);
                check("out rst", Output, 1'b0);
                check("err rst", Error, 1'b0);
                #2;
                Reset = 1'b1;
                return;
            end
            check($sformatf("ant k%0d", k), Antenna, exp_ant[k]);
            check($sformatf("out k%0d", k), Output, exp_out[k]);
            if (!(collide && k == 10)) begin
                exp_err = collide && (k >= 11);
                check($sformatf("err k%0d", k), Error, exp_err);
            end
        end
    endtask

    initial begin
        Reset = 1'b0;
        Start = 1'b0;
        Input = 1'b0;
        #12;
        check("ant reset", Antenna, 1'b0);
        check("out reset", Output, 1'b0);
        check("err reset", Error, 1'b0);
        Reset = 1'b1;

        run_frame(4'b1001, 1'b0, 0);
        run_frame(4'b0000, 1'b0, 0);
        run_frame(4'b1111, 1'b0, 0);
        run_frame(4'($urandom), 1'b1, 0);
        run_frame(4'($urandom), 1'b0, 0);
        run_frame(4'($urandom), 1'b0, 18);
        run_frame(4'b1001, 1'b0, 0);
        for (int n = 0; n < 6; n++) begin
            run_frame(4'($urandom), 1'b0, 0);
        end
        run_frame(4'($urandom), 1'b1, 0);
        run_frame(4'b0110, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
